// File: rtl/icache.sv
// Direct-mapped, single-word-line instruction cache with whole-cache invalidate
// and saturating hit/miss profiling counters.
module icache #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        istb,
  input  logic [31:2] iadr,
  output logic [31:0] idati,
  output logic        iack,
  output logic        mstb,
  output logic [31:2] madr,
  input  logic [31:0] mdati,
  input  logic        mack,
  input  logic        inv,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned IDX_W = DEPTH_LOG2;
  localparam int unsigned TAG_W = 30 - DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic               kill_q, kill_d;
  logic               mstb_q, mstb_d;
  logic [31:2]        fadr_q, fadr_d;
  logic [31:0]        rdat_q, rdat_d;
  logic [15:0]        hit_cnt_q, hit_cnt_d;
  logic [15:0]        miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]   tag_q  [DEPTH];
  logic [31:0]        data_q [DEPTH];

  logic [IDX_W-1:0]   idx_c, fidx_c;
  logic [TAG_W-1:0]   itag_c, ftag_c;
  logic               hit_c, fill_we_c;

  assign idx_c  = iadr[DEPTH_LOG2+1:2];
  assign itag_c = iadr[31:DEPTH_LOG2+2];
  assign fidx_c = fadr_q[DEPTH_LOG2+1:2];
  assign ftag_c = fadr_q[31:DEPTH_LOG2+2];

  assign hit_c = (state_q == IDLE) && istb && valid_q[idx_c] && (tag_q[idx_c] == itag_c);

  // Hit path answers combinationally; everything else comes from registers.
  assign iack     = hit_c || (state_q == RESP);
  assign idati    = hit_c ? data_q[idx_c] : rdat_q;
  assign mstb     = mstb_q;
  assign madr     = fadr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    kill_d     = kill_q;
    mstb_d     = 1'b0;
    fadr_d     = fadr_q;
    rdat_d     = rdat_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    fill_we_c  = 1'b0;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (hit_c) begin
          if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        end else if (istb) begin
          fadr_d  = iadr;
          state_d = FILL;
          mstb_d  = 1'b1;
          kill_d  = inv;
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
      end
      FILL: begin
        mstb_d = 1'b1;
        if (inv) kill_d = 1'b1;
        if (mack) begin
          fill_we_c       = 1'b1;
          valid_d[fidx_c] = ~kill_q;
          rdat_d          = mdati;
          mstb_d          = 1'b0;
          state_d         = RESP;
        end
      end
      RESP: begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Invalidate overrides any fill write landing on the same edge.
    if (inv) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      kill_q     <= 1'b0;
      mstb_q     <= 1'b0;
      fadr_q     <= '0;
      rdat_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      kill_q     <= kill_d;
      mstb_q     <= mstb_d;
      fadr_q     <= fadr_d;
      rdat_q     <= rdat_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data arrays are not reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_we_c) begin
      tag_q[fidx_c]  <= ftag_c;
      data_q[fidx_c] <= mdati;
    end
  end

endmodule
